// File: rtl/ni_pkg.sv
// Shared widths and packet types for the network-interface packet path.
package ni_pkg;
    localparam int FLIT_W      = 16;
    localparam int TOTAL_FLITS = 4;
    localparam int PKT_W       = FLIT_W * TOTAL_FLITS;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [FLIT_W-1:0] header;
        logic [FLIT_W-1:0] addr_hi;
        logic [FLIT_W-1:0] addr_lo;
        logic [FLIT_W-1:0] payload;
    } req_packet_s;

    typedef struct packed {
        logic [FLIT_W-1:0] header;
        logic [FLIT_W-1:0] status;
        logic [FLIT_W-1:0] data_hi;
        logic [FLIT_W-1:0] data_lo;
    } resp_packet_s;
endpackage

// File: rtl/ni_pkt_fifo_mem.sv
// Packet storage: DEPTH x W array, one write port and one registered read port.
module ni_pkt_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Contents are deliberately left unreset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ni_pkt_fifo.sv
// Packet-granular FIFO with level/almost-full reporting, flush and sticky error flags.
module ni_pkt_fifo #(
    parameter int DEPTH    = 4,
    parameter int PKT_W    = ni_pkg::PKT_W,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fifo_wreq,
    input  logic [PKT_W-1:0]                     wdata,
    input  logic                                 fifo_rreq,
    output logic [PKT_W-1:0]                     rdata,
    output logic                                 rvalid,
    output logic                                 fifo_full,
    output logic                                 fifo_empty,
    output logic                                 almost_full,
    output logic [ni_pkg::level_w(DEPTH)-1:0]    level,
    input  logic                                 flush,
    output logic                                 err_ovf,
    output logic                                 err_udf,
    input  logic                                 err_clr
);
    localparam int LVL_W = ni_pkg::level_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_rvalid;
    logic             r_err_ovf;
    logic             r_err_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_evt;
    logic w_udf_evt;

    // Status derives from the registered level only, never from this cycle's requests.
    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = fifo_wreq & ~w_full & ~flush;
    assign w_rd_acc = fifo_rreq & ~w_empty & ~flush;
    assign w_ovf_evt = fifo_wreq & w_full & ~flush;
    assign w_udf_evt = fifo_rreq & w_empty & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_rvalid <= w_rd_acc;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
            r_err_udf <= w_udf_evt | (r_err_udf & ~err_clr);
        end
    end

    ni_pkt_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (PKT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (wdata),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (rdata)
    );

    assign rvalid      = r_rvalid;
    assign fifo_full   = w_full;
    assign fifo_empty  = w_empty;
    assign almost_full = (r_level >= LVL_W'(AFULL_TH));
    assign level       = r_level;
    assign err_ovf     = r_err_ovf;
    assign err_udf     = r_err_udf;
endmodule

// File: tb/tb_ni_pkt_fifo.sv
// Bench for ni_pkt_fifo: directed vector table, reset-mid-burst sequence, random run vs queue model.
module tb_ni_pkt_fifo;
    localparam int DEPTH = 4;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         fifo_wreq;
    logic [W-1:0] wdata;
    logic         fifo_rreq;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         fifo_full;
    logic         fifo_empty;
    logic         almost_full;
    logic [2:0]   level;
    logic         flush;
    logic         err_ovf;
    logic         err_udf;
    logic         err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ni_pkt_fifo #(.DEPTH(DEPTH), .PKT_W(W), .AFULL_TH(DEPTH - 1)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_wreq   (fifo_wreq),
        .wdata       (wdata),
        .fifo_rreq   (fifo_rreq),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .level       (level),
        .flush       (flush),
        .err_ovf     (err_ovf),
        .err_udf     (err_udf),
        .err_clr     (err_clr)
    );

    typedef struct {
        logic         w, r, f, c;
        logic [W-1:0] d;
        int           lvl;
        logic         rv;
        logic [W-1:0] rd;
        logic         full, empty, af, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: a plain queue of packets plus output registers.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_rdata;
    logic         m_rvalid, m_ovf, m_udf;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, r, f, c, input logic [W-1:0] d, input int lvl,
                       input logic rv, input logic [W-1:0] rd,
                       input logic full, empty, af, ovf, udf);
        vec_t v;
        v.w = w; v.r = r; v.f = f; v.c = c; v.d = d; v.lvl = lvl; v.rv = rv; v.rd = rd;
        v.full = full; v.empty = empty; v.af = af; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic step(input logic w, r, f, c, input logic [W-1:0] d);
        fifo_wreq = w; fifo_rreq = r; flush = f; err_clr = c; wdata = d;
        @(posedge clk);
        #1;
        fifo_wreq = 1'b0; fifo_rreq = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_wreq = 1'b0; fifo_rreq = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    // Model applies the behavioural rules directly on the packet queue.
    task automatic model_step(input logic w, r, f, c, input logic [W-1:0] d);
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (f) begin
            mq.delete();
            m_rvalid = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            m_rvalid = r && !was_empty;
            if (m_rvalid) m_rdata = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    function automatic logic [W-1:0] pat(input logic [7:0] b);
        return {8{b}};
    endfunction

    initial begin
        logic [W-1:0] prev;
        reset = 1'b1;
        fifo_wreq = 1'b0; fifo_rreq = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("reset.empty", W'(fifo_empty), W'(1));
        check("reset.full", W'(fifo_full), W'(0));
        check("reset.afull", W'(almost_full), W'(0));
        check("reset.level", W'(level), W'(0));
        check("reset.rvalid", W'(rvalid), W'(0));
        check("reset.rdata", rdata, W'(0));
        check("reset.ovf", W'(err_ovf), W'(0));
        check("reset.udf", W'(err_udf), W'(0));

        //   w  r  f  c  data           lvl rv rdata           F  E  A  O  U
        add(0, 0, 0, 0, '0,            0, 0, '0,            0, 1, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h11),    1, 0, '0,            0, 0, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h22),    2, 0, '0,            0, 0, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h33),    3, 0, '0,            0, 0, 1, 0, 0);
        add(1, 0, 0, 0, pat(8'h44),    4, 0, '0,            1, 0, 1, 0, 0);
        add(1, 0, 0, 0, pat(8'h55),    4, 0, '0,            1, 0, 1, 1, 0);
        add(0, 1, 0, 0, '0,            3, 1, pat(8'h11),    0, 0, 1, 1, 0);
        add(0, 1, 0, 0, '0,            2, 1, pat(8'h22),    0, 0, 0, 1, 0);
        add(0, 1, 0, 0, '0,            1, 1, pat(8'h33),    0, 0, 0, 1, 0);
        add(0, 1, 0, 0, '0,            0, 1, pat(8'h44),    0, 1, 0, 1, 0);
        add(0, 0, 0, 1, '0,            0, 0, pat(8'h44),    0, 1, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h01),    1, 0, pat(8'h44),    0, 0, 0, 0, 0);
        prev = pat(8'h01);
        for (int k = 2; k <= 7; k++) begin
            add(1, 1, 0, 0, pat(8'(k)), 1, 1, prev,        0, 0, 0, 0, 0);
            prev = pat(8'(k));
        end
        add(0, 1, 0, 0, '0,            0, 1, pat(8'h07),    0, 1, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h10),    1, 0, pat(8'h07),    0, 0, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h20),    2, 0, pat(8'h07),    0, 0, 0, 0, 0);
        add(1, 0, 0, 0, pat(8'h30),    3, 0, pat(8'h07),    0, 0, 1, 0, 0);
        add(1, 0, 0, 0, pat(8'h40),    4, 0, pat(8'h07),    1, 0, 1, 0, 0);
        add(1, 1, 0, 0, pat(8'hAA),    3, 1, pat(8'h10),    0, 0, 1, 1, 0);
        add(0, 1, 0, 0, '0,            2, 1, pat(8'h20),    0, 0, 0, 1, 0);
        add(0, 1, 0, 0, '0,            1, 1, pat(8'h30),    0, 0, 0, 1, 0);
        add(0, 1, 0, 0, '0,            0, 1, pat(8'h40),    0, 1, 0, 1, 0);
        add(0, 0, 0, 1, '0,            0, 0, pat(8'h40),    0, 1, 0, 0, 0);
        add(1, 1, 0, 0, pat(8'hBB),    1, 0, pat(8'h40),    0, 0, 0, 0, 1);
        add(0, 1, 0, 0, '0,            0, 1, pat(8'hBB),    0, 1, 0, 0, 1);
        add(1, 0, 0, 0, pat(8'hC1),    1, 0, pat(8'hBB),    0, 0, 0, 0, 1);
        add(1, 0, 0, 0, pat(8'hC2),    2, 0, pat(8'hBB),    0, 0, 0, 0, 1);
        add(1, 0, 0, 0, pat(8'hC3),    3, 0, pat(8'hBB),    0, 0, 1, 0, 1);
        add(1, 1, 1, 0, pat(8'hDD),    0, 0, pat(8'hBB),    0, 1, 0, 0, 1);
        add(0, 1, 0, 0, '0,            0, 0, pat(8'hBB),    0, 1, 0, 0, 1);
        add(0, 0, 0, 1, '0,            0, 0, pat(8'hBB),    0, 1, 0, 0, 0);
        add(0, 1, 0, 1, '0,            0, 0, pat(8'hBB),    0, 1, 0, 0, 1);
        add(0, 0, 0, 1, '0,            0, 0, pat(8'hBB),    0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].c, vecs[i].d);
            $display("vec %0d: w=%0b r=%0b f=%0b c=%0b level=%0d rvalid=%0b rdata=%h ovf=%0b udf=%0b",
                     i, vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].c, level, rvalid, rdata, err_ovf, err_udf);
            check($sformatf("v%0d.level", i), W'(level), W'(vecs[i].lvl));
            check($sformatf("v%0d.rvalid", i), W'(rvalid), W'(vecs[i].rv));
            check($sformatf("v%0d.rdata", i), rdata, vecs[i].rd);
            check($sformatf("v%0d.full", i), W'(fifo_full), W'(vecs[i].full));
            check($sformatf("v%0d.empty", i), W'(fifo_empty), W'(vecs[i].empty));
            check($sformatf("v%0d.afull", i), W'(almost_full), W'(vecs[i].af));
            check($sformatf("v%0d.ovf", i), W'(err_ovf), W'(vecs[i].ovf));
            check($sformatf("v%0d.udf", i), W'(err_udf), W'(vecs[i].udf));
        end

        // Reset pulsed mid-burst with a read in flight.
        step(1, 0, 0, 0, pat(8'hE1));
        step(1, 0, 0, 0, pat(8'hE2));
        step(0, 1, 0, 0, '0);
        check("midrst.pre_rvalid", W'(rvalid), W'(1));
        reset = 1'b1; fifo_rreq = 1'b1; fifo_wreq = 1'b1; wdata = pat(8'hE3);
        @(posedge clk);
        #1;
        reset = 1'b0; fifo_rreq = 1'b0; fifo_wreq = 1'b0;
        $display("midrst: level=%0d rvalid=%0b rdata=%h", level, rvalid, rdata);
        check("midrst.rvalid", W'(rvalid), W'(0));
        check("midrst.level", W'(level), W'(0));
        check("midrst.empty", W'(fifo_empty), W'(1));
        check("midrst.rdata", rdata, W'(0));

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic w, r, f, c;
            logic [W-1:0] d;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 49) == 0);
            c = ($urandom_range(0, 19) == 0);
            d = {$urandom, $urandom};
            step(w, r, f, c, d);
            model_step(w, r, f, c, d);
            $display("rnd %0d: w=%0b r=%0b f=%0b c=%0b level=%0d rvalid=%0b rdata=%h", n, w, r, f, c, level, rvalid, rdata);
            check("rnd.level", W'(level), W'(mq.size()));
            check("rnd.rvalid", W'(rvalid), W'(m_rvalid));
            check("rnd.rdata", rdata, m_rdata);
            check("rnd.full", W'(fifo_full), W'(mq.size() == DEPTH));
            check("rnd.empty", W'(fifo_empty), W'(mq.size() == 0));
            check("rnd.afull", W'(almost_full), W'(mq.size() >= DEPTH - 1));
            check("rnd.ovf", W'(err_ovf), W'(m_ovf));
            check("rnd.udf", W'(err_udf), W'(m_udf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
